reduce_gate_seq: RTL and testbench
==================================

Name: reduce_gate_seq

Overview:
- Parametrised, registered successor to the fixed 4-input OR gate.
- Reduces a WIDTH-bit input vector with one of seven selectable logic functions (OR, AND, XOR, NOR, NAND, XNOR, majority) and reports the popcount alongside.
- Optional sticky accumulation across transactions, for event/interrupt aggregation.
- Single-entry output register with valid/ready handshake, so it can sit between pipelined producers and consumers in the gate library.

Parameters:
- WIDTH, 4, number of input channels (>=2).
- CW, $clog2(WIDTH+1), popcount width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/mode/accum_en qualify this cycle.
- in_ready  output  1  block can accept an input this cycle.
- in_data  input  WIDTH  channel inputs; bit i = channel i.
- mode  input  3  reduction select, sampled with the input.
- accum_en  input  1  1 = OR in_data into the sticky vector and reduce the accumulated value.
- clear  input  1  clear the sticky vector; independent of in_valid.
- out_valid  output  1  out_result/out_count hold a result.
- out_ready  input  1  consumer takes the result this cycle.
- out_result  output  1  reduction result.
- out_count  output  CW  number of 1s in the reduced vector.
- acc_vec  output  WIDTH  current sticky vector (registered).

Behaviour:
- Reset:
  - Async assert of rst_n forces out_valid=0, out_result=0, out_count=0, acc_vec=0 immediately.
  - Deassert is taken synchronously at the next clk edge.
  - Reset mid-transaction drops any pending result; nothing is replayed.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Output fires when out_valid && out_ready.
  - Latency is 1 cycle: an input accepted at edge N makes out_valid high after edge N.
  - Full throughput is one result per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_result, out_count and out_valid hold stable and in_ready=0.
- Drain: a fire with no accept in the same cycle sets out_valid=0 at the next edge.
- Effective vector v at accept:
  - accum_en=0: v = in_data.
  - accum_en=1: v = acc_vec_next | in_data, where acc_vec_next = clear ? 0 : acc_vec.
- Modes:
  - 000 OR = |v; 001 AND = &v; 010 XOR = ^v.
  - 011 NOR = ~|v; 100 NAND = ~&v; 101 XNOR = ~^v.
  - 110 MAJ = (popcount(v) > WIDTH/2, integer divide); with WIDTH=4 this needs 3 or more ones.
  - 111 reserved: out_result=0, out_count still valid.
- out_count = popcount(v) in every mode, zero-extended to CW bits; all-ones gives WIDTH.
- Sticky vector update at each edge:
  - clear && accept && accum_en: acc_vec <= in_data (clear first, then OR).
  - clear otherwise: acc_vec <= 0.
  - accept && accum_en: acc_vec <= acc_vec | in_data.
  - otherwise: hold.
- Accepts with accum_en=0 never modify acc_vec.
- Inputs with in_valid=0 are ignored, except clear.
- mode and accum_en are only sampled on accept; values during a stall have no effect.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid, out_result, out_count, acc_vec all 0 without waiting for a clk edge.
- Exhaustive 16-vector sweep, WIDTH=4, mode=000, out_ready=1:
  - in_data 0000 -> result 0, count 0.
  - 0001 -> 1, count 1.
  - 1111 -> 1, count 4.
  - Every vector produces its result one cycle after accept.
- Modes on in_data=1011 -> OR 1, AND 0, XOR 1, NOR 0, NAND 1, XNOR 0, MAJ 1 (count 3), mode 111 -> 0 with count 3.
- Backpressure:
  - Send 0001 then 1111 with out_ready=0 for 3 cycles -> in_ready=0 and output held at result 1, count 1.
  - Release out_ready -> second result (count 4) appears next cycle; no loss or duplication.
- Accumulate (OR mode, accum_en=1):
  - Send 0001, then 0100 -> acc_vec 0101, count 2.
  - Send 0010 with clear=1 -> acc_vec 0010, count 1.
  - clear alone -> acc_vec 0000.
- Parametrisation: WIDTH=7, AND mode, in_data=1111111 -> result 1, count 7 (CW=3); MAJ with 4 ones -> 1, with 3 ones -> 0.

Source files
------------

// File: rtl/reduce_gate_seq.sv
// reduce_gate_seq: registered WIDTH-input logic reduction with popcount,
// sticky OR accumulation and a single-entry valid/ready output register.
module reduce_gate_seq #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       mode,
    input  logic             accum_en,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [CW-1:0]    out_count,
    output logic [WIDTH-1:0] acc_vec
);
    typedef enum logic [2:0] {
        M_OR   = 3'b000,
        M_AND  = 3'b001,
        M_XOR  = 3'b010,
        M_NOR  = 3'b011,
        M_NAND = 3'b100,
        M_XNOR = 3'b101,
        M_MAJ  = 3'b110,
        M_RSV  = 3'b111
    } mode_e;

    // Majority threshold: strictly more than half (integer divide).
    localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);

    logic             accept;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] vec;
    logic [CW-1:0]    cnt;
    logic             res;

    logic             out_valid_q,  out_valid_d;
    logic             out_result_q, out_result_d;
    logic [CW-1:0]    out_count_q,  out_count_d;
    logic [WIDTH-1:0] acc_vec_q,    acc_vec_d;

    // The slot can take new data when empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Clear applies before the OR, so clear+accumulate yields just in_data.
    assign acc_base = clear ? '0 : acc_vec_q;
    assign vec      = accum_en ? (acc_base | in_data) : in_data;

    // Popcount of the effective vector.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
    end

    // Reduction select; reserved encoding reports 0.
    always_comb begin
        res = 1'b0;
        case (mode_e'(mode))
            M_OR:    res =  |vec;
            M_AND:   res =  &vec;
            M_XOR:   res =  ^vec;
            M_NOR:   res = ~|vec;
            M_NAND:  res = ~&vec;
            M_XNOR:  res = ~^vec;
            M_MAJ:   res = (cnt > HALF);
            default: res = 1'b0;
        endcase
    end

    // Output slot: load on accept, empty on a fire without a refill, else hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_count_d  = out_count_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_result_d = res;
            out_count_d  = cnt;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // Sticky vector: accumulate on accept with accum_en, clear works without in_valid.
    always_comb begin
        acc_vec_d = acc_vec_q;
        if (accept && accum_en) begin
            acc_vec_d = acc_base | in_data;
        end else if (clear) begin
            acc_vec_d = '0;
        end
    end

    // State registers; async reset drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            out_count_q  <= '0;
            acc_vec_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_count_q  <= out_count_d;
            acc_vec_q    <= acc_vec_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_count  = out_count_q;
    assign acc_vec    = acc_vec_q;
endmodule

// File: tb/tb_reduce_gate_seq.sv
// Scoreboard bench for reduce_gate_seq: WIDTH=4 and WIDTH=7 instances.
module tb_reduce_gate_seq;
    typedef struct packed {
        logic       r;
        logic [2:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       in_valid, in_ready, accum_en, clear, out_valid, out_ready, out_result;
    logic [3:0] in_data, acc_vec;
    logic [2:0] mode, out_count;
    // WIDTH=7 instance
    logic       in_valid7, in_ready7, accum_en7, clear7, out_valid7, out_ready7, out_result7;
    logic [6:0] in_data7, acc_vec7;
    logic [2:0] mode7, out_count7;

    exp_t q4[$];
    exp_t q7[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    reduce_gate_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .accum_en(accum_en), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_count(out_count), .acc_vec(acc_vec)
    );

    reduce_gate_seq #(.WIDTH(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7),
        .in_data(in_data7), .mode(mode7), .accum_en(accum_en7), .clear(clear7),
        .out_valid(out_valid7), .out_ready(out_ready7), .out_result(out_result7),
        .out_count(out_count7), .acc_vec(acc_vec7)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop and compare on every output fire.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_output", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("w4_result", out_result, e.r);
                chk("w4_count", out_count, e.c);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid7 && out_ready7) begin
            if (q7.size() == 0) begin
                chk("w7_unexpected_output", 1, 0);
            end else begin
                e = q7.pop_front();
                chk("w7_result", out_result7, e.r);
                chk("w7_count", out_count7, e.c);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one vector, wait (bounded) for acceptance, push its expectation.
    task automatic send4(input logic [3:0] d, input logic [2:0] m, input logic ae,
                         input logic clr, input logic er, input logic [2:0] ec);
        int n = 0;
        in_valid = 1'b1; in_data = d; mode = m; accum_en = ae; clear = clr;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("w4_accept_timeout", 0, 1);
        else q4.push_back('{er, ec});
        @(posedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b0; accum_en = 1'b0;
        chk("w4_latency_valid", out_valid, 1);
    endtask

    task automatic send7(input logic [6:0] d, input logic [2:0] m,
                         input logic er, input logic [2:0] ec);
        int n = 0;
        in_valid7 = 1'b1; in_data7 = d; mode7 = m;
        @(negedge clk);
        while (!in_ready7 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready7) chk("w7_accept_timeout", 0, 1);
        else q7.push_back('{er, ec});
        @(posedge clk);
        #1;
        in_valid7 = 1'b0;
        chk("w7_latency_valid", out_valid7, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        logic [2:0] mres;
        rst_n = 1'b0;
        in_valid = 0; in_data = '0; mode = '0; accum_en = 0; clear = 0; out_ready = 1;
        in_valid7 = 0; in_data7 = '0; mode7 = '0; accum_en7 = 0; clear7 = 0; out_ready7 = 1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_acc_vec", acc_vec, 0);
        chk("reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Mid-cycle async reset with a pending result and non-zero sticky vector
        out_ready = 1'b0;
        send4(4'b0110, 3'b000, 1'b1, 1'b0, 1'b1, 3'd2);
        chk("pre_reset_acc", acc_vec, 4'b0110);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_result", out_result, 0);
        chk("async_rst_out_count", out_count, 0);
        chk("async_rst_acc_vec", acc_vec, 0);
        q4.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Exhaustive OR sweep at full throughput
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            send4(v, 3'b000, 1'b0, 1'b0, (i != 0), 3'($countones(v)));
        end
        idle(2);

        // All modes on 1011
        mres = 3'b000; send4(4'b1011, mres, 0, 0, 1'b1, 3'd3);
        mres = 3'b001; send4(4'b1011, mres, 0, 0, 1'b0, 3'd3);
        mres = 3'b010; send4(4'b1011, mres, 0, 0, 1'b1, 3'd3);
        mres = 3'b011; send4(4'b1011, mres, 0, 0, 1'b0, 3'd3);
        mres = 3'b100; send4(4'b1011, mres, 0, 0, 1'b1, 3'd3);
        mres = 3'b101; send4(4'b1011, mres, 0, 0, 1'b0, 3'd3);
        mres = 3'b110; send4(4'b1011, mres, 0, 0, 1'b1, 3'd3);
        mres = 3'b111; send4(4'b1011, mres, 0, 0, 1'b0, 3'd3);
        // MAJ boundary: two ones is not a majority of four
        send4(4'b0101, 3'b110, 0, 0, 1'b0, 3'd2);
        idle(2);

        // Backpressure: second vector waits while the first is held
        out_ready = 1'b0;
        send4(4'b0001, 3'b000, 0, 0, 1'b1, 3'd1);
        in_valid = 1'b1; in_data = 4'b1111; mode = 3'b000;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_result", out_result, 1);
            chk("stall_out_count", out_count, 1);
        end
        mode = 3'b001;  // changing mode during the stall must not matter
        @(posedge clk);
        #1 out_ready = 1'b1; mode = 3'b000;
        @(negedge clk);
        q4.push_back('{1'b1, 3'd4});
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("release_out_valid", out_valid, 1);
        chk("release_out_count", out_count, 4);
        idle(2);
        chk("drain_out_valid", out_valid, 0);

        // Sticky accumulation
        send4(4'b0001, 3'b000, 1, 0, 1'b1, 3'd1);
        chk("acc_after_0001", acc_vec, 4'b0001);
        send4(4'b0100, 3'b000, 1, 0, 1'b1, 3'd2);
        chk("acc_after_0100", acc_vec, 4'b0101);
        send4(4'b0010, 3'b000, 1, 1, 1'b1, 3'd1);
        chk("acc_clear_and_or", acc_vec, 4'b0010);
        send4(4'b1000, 3'b000, 0, 0, 1'b1, 3'd1);
        chk("acc_untouched_no_accum", acc_vec, 4'b0010);
        in_data = 4'b1111; accum_en = 1'b1;   // ignored: in_valid is low
        @(posedge clk);
        #1;
        chk("acc_ignore_invalid", acc_vec, 4'b0010);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0; accum_en = 1'b0;
        chk("acc_clear_alone", acc_vec, 0);

        // WIDTH=7 instance
        send7(7'b1111111, 3'b001, 1'b1, 3'd7);
        send7(7'b0001111, 3'b110, 1'b1, 3'd4);
        send7(7'b0000111, 3'b110, 1'b0, 3'd3);
        send7(7'b1111110, 3'b001, 1'b0, 3'd6);

        idle(3);
        chk("w4_queue_drained", q4.size(), 0);
        chk("w7_queue_drained", q7.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
